// File: rtl/vga_fade_pkg.sv
// Shared types and helpers for the VGA output stage and its fade engine.
package vga_fade_pkg;

  localparam int unsigned COLOR_W   = 4;
  localparam int unsigned PXL_W     = 10;
  localparam int unsigned LVL_MAX_W = 8;   // widest fade level scale_color accepts
  localparam int unsigned FCNT_W    = 8;   // frame counter, covers FRAMES_PER_STEP up to 255
  localparam int unsigned PROD_W    = COLOR_W + LVL_MAX_W;

  typedef enum logic [1:0] {
    FULL     = 2'd0,
    FADE_OUT = 2'd1,
    DARK     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  // Controller timing entering the display chain
  typedef struct packed {
    logic [PXL_W-1:0] pxl_x;
    logic [PXL_W-1:0] pxl_y;
    logic             en;
  } vga_timing_t;

  // Colour and sync leaving the display chain
  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
  } vga_end_t;

  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
  } vga_rgb_t;

  // Everything driven to the connector / LCD
  typedef struct packed {
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
    logic [PXL_W-1:0]   pxl_x;
    logic [PXL_W-1:0]   pxl_y;
    logic               en;
  } vga_t;

  // Attenuate one channel by level / 2^lvl_w; the full level passes the colour
  // untouched so an idle engine is transparent. lvl_w must not exceed LVL_MAX_W.
  function automatic logic [COLOR_W-1:0] scale_color(
    input logic [COLOR_W-1:0]   c,
    input logic [LVL_MAX_W-1:0] level,
    input int unsigned          lvl_w
  );
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] full_lvl;
    prod     = (PROD_W'(c) * PROD_W'(level)) >> lvl_w;
    full_lvl = (PROD_W'(1) << lvl_w) - PROD_W'(1);
    if (PROD_W'(level) == full_lvl) begin
      return c;
    end
    return COLOR_W'(prod);
  endfunction

endpackage

// File: rtl/vga_fade_out_stage_sync_delay_line.sv
// Fixed-latency shift register for sync lines; idles at all-ones (inactive sync).
module sync_delay_line #(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (LAT == 0) begin : g_wire
    assign dout = din;
  end else begin : g_shift
    logic [W-1:0] taps_q [LAT];
    logic [W-1:0] taps_d [LAT];

    // Each tap takes the previous one; tap 0 takes the input
    always_comb begin
      taps_d[0] = din;
      for (int i = 1; i < int'(LAT); i++) begin
        taps_d[i] = taps_q[i-1];
      end
    end

    // Shift every cycle; reset to inactive sync level
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(LAT); i++) begin
          taps_q[i] <= '1;
        end
      end else begin
        for (int i = 0; i < int'(LAT); i++) begin
          taps_q[i] <= taps_d[i];
        end
      end
    end

    assign dout = taps_q[LAT-1];
  end

endmodule

// File: rtl/vga_fade_out_stage.sv
// Final VGA output stage: one-cycle colour/coordinate retime with blanking,
// delayed sync, and a frame-locked fade-to-black engine.
module vga_fade_out_stage
  import vga_fade_pkg::*;
#(
  parameter int unsigned RGB_LAT         = 0,
  parameter int unsigned LVL_W           = 4,
  parameter int unsigned FRAMES_PER_STEP = 2
) (
  input  logic             clk_25,
  input  logic             resetN,
  input  vga_timing_t      vga_chain_start,
  input  vga_end_t         vga_chain_end,
  output vga_t             vga_out,
  input  logic             fade_out_req,
  input  logic             fade_in_req,
  output logic             fade_busy,
  output logic             fade_done,
  output logic [LVL_W-1:0] fade_level
);

  localparam logic [LVL_W-1:0]  LVL_FULL  = '1;
  localparam logic [LVL_W-1:0]  LVL_ZERO  = '0;
  localparam logic [FCNT_W-1:0] STEP_LAST = FCNT_W'(FRAMES_PER_STEP - 1);

  fade_state_t       state_q, state_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [FCNT_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              vs_prev_q, vs_prev_d;
  logic              frame_tick;
  logic              step_en;
  vga_timing_t       timing_q, timing_d;
  vga_rgb_t          rgb_q, rgb_d;
  logic [1:0]        sync_out;

  // Falling edge of the chain's vsync marks a frame boundary
  assign frame_tick = vs_prev_q & ~vga_chain_end.vsync;

  // Next colour: blanked outside active video, otherwise scaled by the current level
  always_comb begin
    timing_d  = vga_chain_start;
    vs_prev_d = vga_chain_end.vsync;
    rgb_d     = '0;
    if (vga_chain_start.en) begin
      rgb_d.red   = scale_color(vga_chain_end.red,   LVL_MAX_W'(level_q), LVL_W);
      rgb_d.green = scale_color(vga_chain_end.green, LVL_MAX_W'(level_q), LVL_W);
      rgb_d.blue  = scale_color(vga_chain_end.blue,  LVL_MAX_W'(level_q), LVL_W);
    end
  end

  // Fade engine next state: apply any frame step first, then the requests
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    step_en = 1'b0;

    if ((state_q == FADE_OUT || state_q == FADE_IN) && frame_tick) begin
      if (cnt_q == STEP_LAST) begin
        step_en = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + FCNT_W'(1);
      end
    end

    if (step_en) begin
      if (state_q == FADE_OUT) begin
        level_d = (level_q == LVL_ZERO) ? LVL_ZERO : level_q - LVL_W'(1);
        if (level_d == LVL_ZERO) begin
          state_d = DARK;
          done_d  = 1'b1;
        end
      end else begin
        level_d = (level_q == LVL_FULL) ? LVL_FULL : level_q + LVL_W'(1);
        if (level_d == LVL_FULL) begin
          state_d = FULL;
          done_d  = 1'b1;
        end
      end
    end

    // Requests act on the post-step state; fade-out wins a tie
    case (state_d)
      FULL, FADE_IN: begin
        if (fade_out_req) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end
      end
      DARK, FADE_OUT: begin
        if (fade_in_req && !fade_out_req) begin
          state_d = FADE_IN;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase

    busy_d = (state_d == FADE_OUT) || (state_d == FADE_IN);
  end

  // Fade engine registers with registered status outputs
  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      state_q <= FULL;
      level_q <= LVL_FULL;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // One-cycle retime of colour, coordinates, enable and the vsync edge detector
  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      timing_q  <= '0;
      rgb_q     <= '0;
      vs_prev_q <= 1'b1;
    end else begin
      timing_q  <= timing_d;
      rgb_q     <= rgb_d;
      vs_prev_q <= vs_prev_d;
    end
  end

  sync_delay_line #(
    .LAT (RGB_LAT),
    .W   (2)
  ) u_sync_delay (
    .clk   (clk_25),
    .rst_n (resetN),
    .din   ({vga_chain_end.hsync, vga_chain_end.vsync}),
    .dout  (sync_out)
  );

  // Assemble the connector bus
  always_comb begin
    vga_out.red   = rgb_q.red;
    vga_out.green = rgb_q.green;
    vga_out.blue  = rgb_q.blue;
    vga_out.hsync = sync_out[1];
    vga_out.vsync = sync_out[0];
    vga_out.pxl_x = timing_q.pxl_x;
    vga_out.pxl_y = timing_q.pxl_y;
    vga_out.en    = timing_q.en;
  end

  assign fade_busy  = busy_q;
  assign fade_done  = done_q;
  assign fade_level = level_q;

endmodule

// File: tb/tb_vga_fade_out_stage.sv
// Randomized scoreboard bench for vga_fade_out_stage with a behavioural fade model.
module tb_vga_fade_out_stage;
  import vga_fade_pkg::*;

  localparam int unsigned LAT   = 3;
  localparam int unsigned LW    = 4;
  localparam int unsigned FPS   = 2;
  localparam int          FULLV = (1 << LW) - 1;

  logic          clk_25 = 1'b0;
  logic          resetN = 1'b0;
  vga_timing_t   start_s;
  vga_end_t      end_s;
  vga_t          vga_out;
  logic          fade_out_req = 1'b0;
  logic          fade_in_req  = 1'b0;
  logic          fade_busy;
  logic          fade_done;
  logic [LW-1:0] fade_level;

  always #20 clk_25 = ~clk_25;

  vga_fade_out_stage #(
    .RGB_LAT         (LAT),
    .LVL_W           (LW),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clk_25          (clk_25),
    .resetN          (resetN),
    .vga_chain_start (start_s),
    .vga_chain_end   (end_s),
    .vga_out         (vga_out),
    .fade_out_req    (fade_out_req),
    .fade_in_req     (fade_in_req),
    .fade_busy       (fade_busy),
    .fade_done       (fade_done),
    .fade_level      (fade_level)
  );

  typedef struct {
    int r, g, b, hs, vs, x, y, en, lvl, busy, done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Reference model: level, fade direction (-1/0/+1), frames since last step
  int m_lvl, m_dir, m_frames, m_prev_vs;
  int hist_hs[$], hist_vs[$];
  int vcnt = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int ref_scale(int c, int l);
    if (l == FULLV) return c;
    return (c * l) / (1 << LW);
  endfunction

  task automatic model_reset();
    m_lvl = FULLV; m_dir = 0; m_frames = 0; m_prev_vs = 1;
    hist_hs.delete(); hist_vs.delete();
    for (int i = 0; i < int'(LAT); i++) begin
      hist_hs.push_back(1); hist_vs.push_back(1);
    end
    sb.delete();
  endtask

  // Called at each active edge with the inputs the DUT is sampling there
  task automatic model_edge();
    exp_t e;
    int   tick;
    int   en_i;
    en_i = int'(start_s.en);
    e.r  = en_i != 0 ? ref_scale(int'(end_s.red),   m_lvl) : 0;
    e.g  = en_i != 0 ? ref_scale(int'(end_s.green), m_lvl) : 0;
    e.b  = en_i != 0 ? ref_scale(int'(end_s.blue),  m_lvl) : 0;
    e.x  = int'(start_s.pxl_x);
    e.y  = int'(start_s.pxl_y);
    e.en = en_i;
    hist_hs.push_back(int'(end_s.hsync));
    hist_vs.push_back(int'(end_s.vsync));
    e.hs = hist_hs[hist_hs.size() - LAT];
    e.vs = hist_vs[hist_vs.size() - LAT];
    void'(hist_hs.pop_front());
    void'(hist_vs.pop_front());

    tick      = (m_prev_vs == 1 && end_s.vsync == 1'b0) ? 1 : 0;
    m_prev_vs = int'(end_s.vsync);
    e.done    = 0;
    if (m_dir != 0 && tick != 0) begin
      m_frames++;
      if (m_frames == int'(FPS)) begin
        m_frames = 0;
        m_lvl = m_lvl + m_dir;
        if (m_lvl < 0) m_lvl = 0;
        if (m_lvl > FULLV) m_lvl = FULLV;
        if (m_lvl == 0 || m_lvl == FULLV) begin
          m_dir  = 0;
          e.done = 1;
        end
      end
    end
    if (fade_out_req && (m_dir == 1 || (m_dir == 0 && m_lvl == FULLV))) begin
      m_dir = -1; m_frames = 0;
    end else if (fade_in_req && !fade_out_req && (m_dir == -1 || (m_dir == 0 && m_lvl == 0))) begin
      m_dir = 1; m_frames = 0;
    end
    e.lvl  = m_lvl;
    e.busy = (m_dir != 0) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic drive_random(bit oreq, bit ireq);
    start_s.pxl_x = PXL_W'($urandom_range(0, 1023));
    start_s.pxl_y = PXL_W'($urandom_range(0, 1023));
    start_s.en    = ($urandom_range(0, 3) != 0);
    end_s.red     = COLOR_W'($urandom_range(0, 15));
    end_s.green   = COLOR_W'($urandom_range(0, 15));
    end_s.blue    = COLOR_W'($urandom_range(0, 15));
    if (m_lvl == 8) end_s.red = 4'hF;
    end_s.hsync   = ($urandom_range(0, 1) != 0);
    vcnt          = (vcnt + 1) % 8;
    end_s.vsync   = (vcnt >= 2);
    fade_out_req  = oreq;
    fade_in_req   = ireq;
  endtask

  task automatic cycle(bit oreq, bit ireq);
    @(posedge clk_25);
    model_edge();
    #1;
    drive_random(oreq, ireq);
  endtask

  task automatic run_until(int want_lvl, int want_dir, int limit, string name);
    int n;
    n = 0;
    while (!(m_lvl == want_lvl && m_dir == want_dir) && n < limit) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    chk(name, (n < limit) ? int'(fade_level) : -1, want_lvl);
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_hsync"}, int'(vga_out.hsync), 1);
    chk({tag, "_vsync"}, int'(vga_out.vsync), 1);
    chk({tag, "_red"},   int'(vga_out.red),   0);
    chk({tag, "_x"},     int'(vga_out.pxl_x), 0);
    chk({tag, "_en"},    int'(vga_out.en),    0);
    chk({tag, "_level"}, int'(fade_level),    FULLV);
    chk({tag, "_busy"},  int'(fade_busy),     0);
    chk({tag, "_done"},  int'(fade_done),     0);
  endtask

  // Monitor: outputs are continuous, so one scoreboard entry per clock
  initial begin
    forever begin
      @(negedge clk_25);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("red",   int'(vga_out.red),   mon_e.r);
        chk("green", int'(vga_out.green), mon_e.g);
        chk("blue",  int'(vga_out.blue),  mon_e.b);
        chk("hsync", int'(vga_out.hsync), mon_e.hs);
        chk("vsync", int'(vga_out.vsync), mon_e.vs);
        chk("pxl_x", int'(vga_out.pxl_x), mon_e.x);
        chk("pxl_y", int'(vga_out.pxl_y), mon_e.y);
        chk("en",    int'(vga_out.en),    mon_e.en);
        chk("level", int'(fade_level),    mon_e.lvl);
        chk("busy",  int'(fade_busy),     mon_e.busy);
        chk("done",  int'(fade_done),     mon_e.done);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    drive_random(1'b0, 1'b0);
    repeat (4) begin
      @(posedge clk_25);
      #1;
      drive_random(1'b0, 1'b0);
      #5;
      reset_checks("rst");
    end
    model_reset();
    resetN = 1'b1;

    repeat (20) cycle(1'b0, 1'b0);

    // Blanking and coordinate pass-through with a fixed pattern
    cycle(1'b0, 1'b0);
    start_s.pxl_x = PXL_W'(100);
    start_s.en    = 1'b0;
    end_s.red     = 4'hF;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // fade_in_req in FULL is ignored
    cycle(1'b0, 1'b1);
    repeat (4) cycle(1'b0, 1'b0);
    chk("ignore_in_full", int'(fade_busy), 0);

    // Simultaneous requests in FULL: fade-out wins
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b0);
    chk("prio_busy", int'(fade_busy), 1);
    run_until(14, -1, 100, "first_step");
    run_until(0, 0, 400, "reach_dark");

    // fade_out_req in DARK is ignored
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);
    chk("ignore_out_dark", int'(fade_busy), 0);

    cycle(1'b0, 1'b1);
    run_until(FULLV, 0, 400, "reach_full");

    // Reversal mid fade-out
    cycle(1'b1, 1'b0);
    run_until(9, -1, 400, "reach_9");
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("rev_busy", int'(fade_busy), 1);
    run_until(10, 1, 100, "rev_10");
    run_until(FULLV, 0, 200, "rev_full");

    // Asynchronous reset in the middle of a fade-in
    cycle(1'b1, 1'b0);
    run_until(0, 0, 400, "dark_again");
    cycle(1'b0, 1'b1);
    run_until(5, 1, 200, "fade_in_5");
    #1;
    resetN = 1'b0;
    sb.delete();
    #1;
    reset_checks("arst");
    repeat (2) begin
      @(posedge clk_25);
      #1;
      drive_random(1'b0, 1'b0);
    end
    model_reset();
    resetN = 1'b1;

    // Random requests, including collisions with step ticks
    repeat (600) cycle($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0);

    @(negedge clk_25);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
